// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode slot, forwarding sources, hazard controls and the
// registered/forwarded EX-side outputs that feed the ALU.
interface id_ex_stage_if;
    logic        i_id_valid;
    logic [31:0] i_id_pc;
    logic [31:0] i_id_rs1_data;
    logic [31:0] i_id_rs2_data;
    logic [31:0] i_id_imm;
    logic [4:0]  i_id_rs1_addr;
    logic [4:0]  i_id_rs2_addr;
    logic [4:0]  i_id_rd_addr;
    logic        i_id_rd_wren;
    logic [3:0]  i_id_alu_op;
    logic        i_id_opa_sel;
    logic        i_id_opb_sel;
    logic        i_id_mem_rd;
    logic        i_id_mem_wr;
    logic [4:0]  i_exmem_rd_addr;
    logic        i_exmem_rd_wren;
    logic [31:0] i_exmem_data;
    logic [4:0]  i_memwb_rd_addr;
    logic        i_memwb_rd_wren;
    logic [31:0] i_memwb_data;
    logic        i_stall;
    logic        i_flush;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_op_a;
    logic [31:0] o_op_b;
    logic [3:0]  o_alu_op;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd_addr;
    logic        o_rd_wren;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic        o_load_use;

    modport master (
        output i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_rd_wren, i_id_alu_op,
               i_id_opa_sel, i_id_opb_sel, i_id_mem_rd, i_id_mem_wr,
               i_exmem_rd_addr, i_exmem_rd_wren, i_exmem_data,
               i_memwb_rd_addr, i_memwb_rd_wren, i_memwb_data, i_stall, i_flush,
        input  o_valid, o_pc, o_op_a, o_op_b, o_alu_op, o_store_data,
               o_rd_addr, o_rd_wren, o_mem_rd, o_mem_wr, o_load_use
    );

    modport slave (
        input  i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_rd_wren, i_id_alu_op,
               i_id_opa_sel, i_id_opb_sel, i_id_mem_rd, i_id_mem_wr,
               i_exmem_rd_addr, i_exmem_rd_wren, i_exmem_data,
               i_memwb_rd_addr, i_memwb_rd_wren, i_memwb_data, i_stall, i_flush,
        output o_valid, o_pc, o_op_a, o_op_b, o_alu_op, o_store_data,
               o_rd_addr, o_rd_wren, o_mem_rd, o_mem_wr, o_load_use
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, ALU operand selection,
// load-use bubble insertion, stall hold with writeback refresh, and flush.
module id_ex_stage (
    input logic          i_clk,
    input logic          i_reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_wren;
        logic [3:0]  alu_op;
        logic        opa_sel;
        logic        opb_sel;
        logic        mem_rd;
        logic        mem_wr;
    } ex_reg_t;

    ex_reg_t     ex_q;
    ex_reg_t     ex_d;
    ex_reg_t     id_slot;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic        load_use;

    // EX/MEM beats MEM/WB; x0 is never forwarded.
    function automatic logic [31:0] forward(
        input logic [4:0]  rs,
        input logic [31:0] held,
        input logic        exm_wren,
        input logic [4:0]  exm_rd,
        input logic [31:0] exm_data,
        input logic        mwb_wren,
        input logic [4:0]  mwb_rd,
        input logic [31:0] mwb_data
    );
        if (rs != 5'd0 && exm_wren && exm_rd == rs)      return exm_data;
        else if (rs != 5'd0 && mwb_wren && mwb_rd == rs) return mwb_data;
        else                                             return held;
    endfunction

    always_comb begin
        id_slot = '0;
        if (bus.i_id_valid) begin
            id_slot = '{valid:    1'b1,
                        pc:       bus.i_id_pc,
                        rs1_data: bus.i_id_rs1_data,
                        rs2_data: bus.i_id_rs2_data,
                        imm:      bus.i_id_imm,
                        rs1_addr: bus.i_id_rs1_addr,
                        rs2_addr: bus.i_id_rs2_addr,
                        rd_addr:  bus.i_id_rd_addr,
                        rd_wren:  bus.i_id_rd_wren,
                        alu_op:   bus.i_id_alu_op,
                        opa_sel:  bus.i_id_opa_sel,
                        opb_sel:  bus.i_id_opb_sel,
                        mem_rd:   bus.i_id_mem_rd,
                        mem_wr:   bus.i_id_mem_wr};
        end
    end

    assign load_use = ex_q.valid && ex_q.mem_rd && ex_q.rd_addr != 5'd0 && bus.i_id_valid
                   && (ex_q.rd_addr == bus.i_id_rs1_addr || ex_q.rd_addr == bus.i_id_rs2_addr)
                   && !bus.i_flush;

    always_comb begin
        // NOTE: defaulting ex_d to the held value first keeps every path assigned, so no latch is inferred.
        ex_d = ex_q;
        if (bus.i_flush) begin
            ex_d = '0;
        end else if (bus.i_stall) begin
            // A value retiring from MEM/WB during the hold would otherwise be lost.
            ex_d.rs1_data = forward(ex_q.rs1_addr, ex_q.rs1_data, 1'b0, 5'd0, 32'd0,
                                    bus.i_memwb_rd_wren, bus.i_memwb_rd_addr, bus.i_memwb_data);
            ex_d.rs2_data = forward(ex_q.rs2_addr, ex_q.rs2_data, 1'b0, 5'd0, 32'd0,
                                    bus.i_memwb_rd_wren, bus.i_memwb_rd_addr, bus.i_memwb_data);
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d = id_slot;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) ex_q <= '0;
        else          ex_q <= ex_d;
    end

    assign fwd_rs1 = forward(ex_q.rs1_addr, ex_q.rs1_data,
                             bus.i_exmem_rd_wren, bus.i_exmem_rd_addr, bus.i_exmem_data,
                             bus.i_memwb_rd_wren, bus.i_memwb_rd_addr, bus.i_memwb_data);
    assign fwd_rs2 = forward(ex_q.rs2_addr, ex_q.rs2_data,
                             bus.i_exmem_rd_wren, bus.i_exmem_rd_addr, bus.i_exmem_data,
                             bus.i_memwb_rd_wren, bus.i_memwb_rd_addr, bus.i_memwb_data);

    assign bus.o_valid      = ex_q.valid;
    assign bus.o_pc         = ex_q.pc;
    assign bus.o_op_a       = ex_q.opa_sel ? ex_q.pc  : fwd_rs1;
    assign bus.o_op_b       = ex_q.opb_sel ? ex_q.imm : fwd_rs2;
    assign bus.o_alu_op     = ex_q.alu_op;
    assign bus.o_store_data = fwd_rs2;
    assign bus.o_rd_addr    = ex_q.rd_addr;
    assign bus.o_rd_wren    = ex_q.rd_wren;
    assign bus.o_mem_rd     = ex_q.mem_rd;
    assign bus.o_mem_wr     = ex_q.mem_wr;
    assign bus.o_load_use   = load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for capture/forwarding/select,
// plus hand sequences for reset, load-use, stall refresh and flush.
module tb_id_ex_stage;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wren;
        logic [3:0]  alu_op;
        logic        opa_sel;
        logic        opb_sel;
        logic        mem_rd;
        logic        mem_wr;
    } id_t;

    typedef struct packed {
        logic [4:0]  exm_rd;
        logic        exm_wren;
        logic [31:0] exm_data;
        logic [4:0]  mwb_rd;
        logic        mwb_wren;
        logic [31:0] mwb_data;
    } fwd_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] store_data;
        logic [3:0]  alu_op;
        logic [4:0]  rd_addr;
        logic        rd_wren;
        logic        mem_rd;
        logic        mem_wr;
    } exp_t;

    typedef struct {
        id_t  id;
        fwd_t fwd;
        exp_t exp;
    } vec_t;

    localparam fwd_t FWD_IDLE = '0;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs [9];

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_id(input id_t v);
        bus.i_id_valid    = v.valid;
        bus.i_id_pc       = v.pc;
        bus.i_id_rs1_data = v.rs1_data;
        bus.i_id_rs2_data = v.rs2_data;
        bus.i_id_imm      = v.imm;
        bus.i_id_rs1_addr = v.rs1;
        bus.i_id_rs2_addr = v.rs2;
        bus.i_id_rd_addr  = v.rd;
        bus.i_id_rd_wren  = v.rd_wren;
        bus.i_id_alu_op   = v.alu_op;
        bus.i_id_opa_sel  = v.opa_sel;
        bus.i_id_opb_sel  = v.opb_sel;
        bus.i_id_mem_rd   = v.mem_rd;
        bus.i_id_mem_wr   = v.mem_wr;
    endtask

    task automatic drive_fwd(input fwd_t f);
        bus.i_exmem_rd_addr = f.exm_rd;
        bus.i_exmem_rd_wren = f.exm_wren;
        bus.i_exmem_data    = f.exm_data;
        bus.i_memwb_rd_addr = f.mwb_rd;
        bus.i_memwb_rd_wren = f.mwb_wren;
        bus.i_memwb_data    = f.mwb_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // id: valid pc rs1_data rs2_data imm rs1 rs2 rd rd_wren alu opa opb mrd mwr
        // fwd: exm_rd exm_wren exm_data mwb_rd mwb_wren mwb_data
        // exp: valid pc op_a op_b store alu rd rd_wren mrd mwr
        vecs[0] = '{'{1'b1, 32'h10, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0},
                    '{1'b1, 32'h10, 32'd5, 32'd7, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0, 1'b0}};
        vecs[1] = '{'{1'b1, 32'h14, 32'h11, 32'h22, 32'd0, 5'd4, 5'd5, 5'd6, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{5'd4, 1'b1, 32'h99, 5'd0, 1'b0, 32'd0},
                    '{1'b1, 32'h14, 32'h99, 32'h22, 32'h22, 4'd8, 5'd6, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{'{1'b1, 32'h18, 32'h11, 32'h22, 32'd0, 5'd4, 5'd5, 5'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{5'd0, 1'b0, 32'd0, 5'd5, 1'b1, 32'h55},
                    '{1'b1, 32'h18, 32'h11, 32'h55, 32'h55, 4'd0, 5'd7, 1'b1, 1'b0, 1'b0}};
        vecs[3] = '{'{1'b1, 32'h1c, 32'h3, 32'd0, 32'd0, 5'd3, 5'd0, 5'd8, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{5'd3, 1'b1, 32'hAAAA_0000, 5'd3, 1'b1, 32'h1234},
                    '{1'b1, 32'h1c, 32'hAAAA_0000, 32'd0, 32'd0, 4'd0, 5'd8, 1'b1, 1'b0, 1'b0}};
        vecs[4] = '{'{1'b1, 32'h1c, 32'h3, 32'd0, 32'd0, 5'd3, 5'd0, 5'd8, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{5'd3, 1'b0, 32'hAAAA_0000, 5'd3, 1'b1, 32'h1234},
                    '{1'b1, 32'h1c, 32'h1234, 32'd0, 32'd0, 4'd0, 5'd8, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{'{1'b1, 32'h20, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{5'd0, 1'b1, 32'hFFFF, 5'd0, 1'b1, 32'hEEEE},
                    '{1'b1, 32'h20, 32'd0, 32'd0, 32'd0, 4'd0, 5'd9, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{'{1'b1, 32'h100, 32'h5, 32'h77, 32'hFFFF_FFFC, 5'd2, 5'd6, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1},
                    '{5'd6, 1'b1, 32'hCAFE, 5'd0, 1'b0, 32'd0},
                    '{1'b1, 32'h100, 32'h100, 32'hFFFF_FFFC, 32'hCAFE, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1}};
        vecs[7] = '{'{1'b0, 32'h200, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0},
                    '{5'd0, 1'b1, 32'h1111, 5'd0, 1'b1, 32'h2222},
                    '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0}};
        vecs[8] = '{'{1'b1, 32'h24, 32'h1, 32'h2, 32'd0, 5'd10, 5'd11, 5'd12, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0},
                    '{5'd11, 1'b1, 32'h8000_0000, 5'd10, 1'b1, 32'hF0},
                    '{1'b1, 32'h24, 32'hF0, 32'h8000_0000, 32'h8000_0000, 4'd13, 5'd12, 1'b1, 1'b0, 1'b0}};

        rst_n = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive_id('0);
        drive_fwd(FWD_IDLE);
        #2;
        check("reset.valid", bus.o_valid, 1'b0);
        check("reset.pc", bus.o_pc, 32'd0);
        check("reset.op_a", bus.o_op_a, 32'd0);
        check("reset.op_b", bus.o_op_b, 32'd0);
        check("reset.load_use", bus.o_load_use, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            drive_id(vecs[i].id);
            drive_fwd(vecs[i].fwd);
            step();
            check($sformatf("v%0d.valid", i), bus.o_valid, vecs[i].exp.valid);
            check($sformatf("v%0d.pc", i), bus.o_pc, vecs[i].exp.pc);
            check($sformatf("v%0d.op_a", i), bus.o_op_a, vecs[i].exp.op_a);
            check($sformatf("v%0d.op_b", i), bus.o_op_b, vecs[i].exp.op_b);
            check($sformatf("v%0d.store", i), bus.o_store_data, vecs[i].exp.store_data);
            check($sformatf("v%0d.alu_op", i), bus.o_alu_op, vecs[i].exp.alu_op);
            check($sformatf("v%0d.rd_addr", i), bus.o_rd_addr, vecs[i].exp.rd_addr);
            check($sformatf("v%0d.rd_wren", i), bus.o_rd_wren, vecs[i].exp.rd_wren);
            check($sformatf("v%0d.mem_rd", i), bus.o_mem_rd, vecs[i].exp.mem_rd);
            check($sformatf("v%0d.mem_wr", i), bus.o_mem_wr, vecs[i].exp.mem_wr);
            check($sformatf("v%0d.load_use", i), bus.o_load_use, 1'b0);
        end

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        drive_fwd(FWD_IDLE);
        drive_id('{1'b1, 32'h40, 32'h1000, 32'd0, 32'd4, 5'd1, 5'd0, 5'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        step();
        drive_id('{1'b1, 32'h44, 32'hBAD, 32'h10, 32'd0, 5'd5, 5'd1, 5'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        check("lu.detect", bus.o_load_use, 1'b1);
        check("lu.load_in_ex", bus.o_mem_rd, 1'b1);
        step();
        check("lu.bubble_valid", bus.o_valid, 1'b0);
        check("lu.bubble_rd_wren", bus.o_rd_wren, 1'b0);
        check("lu.bubble_clear", bus.o_load_use, 1'b0);
        step();
        drive_fwd('{5'd5, 1'b1, 32'h1234_5678, 5'd0, 1'b0, 32'd0});
        #1;
        check("lu.add_valid", bus.o_valid, 1'b1);
        check("lu.add_rd", bus.o_rd_addr, 5'd6);
        check("lu.fwd_op_a", bus.o_op_a, 32'h1234_5678);
        check("lu.op_b", bus.o_op_b, 32'h10);

        // Stall together with load-use: hold wins, no bubble.
        drive_fwd(FWD_IDLE);
        drive_id('{1'b1, 32'h40, 32'h1000, 32'd0, 32'd4, 5'd1, 5'd0, 5'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        step();
        drive_id('{1'b1, 32'h44, 32'hBAD, 32'h10, 32'd0, 5'd5, 5'd1, 5'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        bus.i_stall = 1'b1;
        step();
        check("stall_lu.valid", bus.o_valid, 1'b1);
        check("stall_lu.pc", bus.o_pc, 32'h40);
        check("stall_lu.load_use", bus.o_load_use, 1'b1);

        // Flush with stall and a store using x5 in ID: flush wins, load_use masked.
        drive_id('{1'b1, 32'h48, 32'h2000, 32'd0, 32'd0, 5'd2, 5'd5, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        bus.i_flush = 1'b1;
        #1;
        check("flush.lu_masked", bus.o_load_use, 1'b0);
        step();
        check("flush.valid", bus.o_valid, 1'b0);
        check("flush.mem_wr", bus.o_mem_wr, 1'b0);
        check("flush.load_use", bus.o_load_use, 1'b0);
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b0;

        // Stall refresh: EX reads x9; MEM/WB retires x9 during a 3-cycle hold.
        drive_id('{1'b1, 32'h60, 32'h3, 32'd0, 32'd0, 5'd2, 5'd9, 5'd13, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        step();
        drive_id('{1'b1, 32'h64, 32'h1, 32'h1, 32'd0, 5'd1, 5'd1, 5'd14, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_fwd('{5'd0, 1'b0, 32'd0, 5'd9, 1'b1, 32'hDEAD_BEEF});
        bus.i_stall = 1'b1;
        #1;
        check("refresh.fwd_during", bus.o_op_b, 32'hDEAD_BEEF);
        step();
        drive_fwd(FWD_IDLE);
        step();
        step();
        bus.i_stall = 1'b0;
        #1;
        check("refresh.held_op_b", bus.o_op_b, 32'hDEAD_BEEF);
        check("refresh.held_pc", bus.o_pc, 32'h60);
        step();
        check("refresh.next_pc", bus.o_pc, 32'h64);

        // Reset asserted mid-stall clears EX without a clock edge.
        drive_id('{1'b1, 32'h80, 32'h9, 32'h8, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0});
        step();
        bus.i_stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.valid", bus.o_valid, 1'b0);
        check("rst_mid.pc", bus.o_pc, 32'd0);
        check("rst_mid.op_a", bus.o_op_a, 32'd0);
        check("rst_mid.alu_op", bus.o_alu_op, 4'd0);
        check("rst_mid.rd_wren", bus.o_rd_wren, 1'b0);
        bus.i_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_id('{1'b1, 32'h90, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        step();
        check("post_rst.op_a", bus.o_op_a, 32'd5);
        check("post_rst.op_b", bus.o_op_b, 32'd7);
        check("post_rst.alu_op", bus.o_alu_op, 4'd0);
        check("post_rst.valid", bus.o_valid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
